// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - game_sequencer control, tick handshake and status signal bundle
interface game_sequencer_if #(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 8,
    parameter int DIV_W     = 20
) ();
    logic                           i_restart;   // synchronous game restart
    logic [N_PLAYERS-1:0]           i_start;     // per-player join/start request
    logic                           i_pause;     // pause toggle pulse
    logic                           i_mode_ext;  // 1: ticks from i_phase edges, 0: internal divider
    logic                           i_phase;     // external tick phase
    logic [DIV_W-1:0]               i_div;       // internal tick period minus 1
    logic [N_PLAYERS-1:0]           i_ready;     // channel can take a tick
    logic [N_PLAYERS-1:0]           i_ack;       // channel consumed its tick
    logic [N_PLAYERS-1:0]           i_fail;      // per-channel failure pulse
    logic [N_PLAYERS-1:0]           i_success;   // per-channel success pulse
    logic [N_PLAYERS-1:0]           i_eat;       // per-channel score pulse
    logic [N_PLAYERS-1:0]           o_tick;      // tick request, held until acked
    logic [N_PLAYERS-1:0]           o_missed;    // dropped tick pulse
    logic [2:0]                     o_state;     // game state
    logic [N_PLAYERS-1:0]           o_failure;   // sticky failure flags
    logic [N_PLAYERS-1:0]           o_success;   // sticky success flags
    logic [N_PLAYERS*SCORE_W-1:0]   o_score;     // packed per-player scores

    modport master (
        output i_restart, i_start, i_pause, i_mode_ext, i_phase, i_div,
               i_ready, i_ack, i_fail, i_success, i_eat,
        input  o_tick, o_missed, o_state, o_failure, o_success, o_score
    );

    modport slave (
        input  i_restart, i_start, i_pause, i_mode_ext, i_phase, i_div,
               i_ready, i_ack, i_fail, i_success, i_eat,
        output o_tick, o_missed, o_state, o_failure, o_success, o_score
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - multi-player game state machine with per-channel tick handshake and scoring
module game_sequencer #(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 8,
    parameter int DIV_W     = 20
) (
    input  logic          clk,    // single clock, rising edge
    input  logic          rst_n,  // asynchronous active-low reset
    game_sequencer_if.slave bus   // game control inputs, tick handshake, status outputs
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t                       state_q, state_d;
    logic [N_PLAYERS-1:0]         active_q, active_d;
    logic [N_PLAYERS-1:0]         tick_q, tick_d;
    logic [N_PLAYERS-1:0]         missed_q, missed_d;
    logic [N_PLAYERS-1:0]         fail_q, fail_d;
    logic [N_PLAYERS-1:0]         succ_q, succ_d;
    logic [N_PLAYERS*SCORE_W-1:0] score_q, score_d;
    logic [DIV_W-1:0]             div_q, div_d;
    logic                         phase_q, phase_d;

    logic                         run;
    logic                         tick_event;
    logic [N_PLAYERS-1:0]         eligible;
    logic                         all_failed;
    logic                         win;

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        tick_d     = tick_q;
        missed_d   = '0;
        fail_d     = fail_q;
        succ_d     = succ_q;
        score_d    = score_q;
        div_d      = div_q;
        // Tracking i_phase every cycle means a paused or idle game never
        // sees a backlog of phase changes when it resumes.
        phase_d    = bus.i_phase;

        run        = (state_q == S_RUN);
        tick_event = 1'b0;
        if (run) begin
            tick_event = bus.i_mode_ext ? (bus.i_phase != phase_q) : (div_q == bus.i_div);
        end

        if (state_q == S_IDLE || state_q == S_RUN) begin
            active_d = active_q | bus.i_start;
        end

        // A tick is offered only to a live, ready channel; if it is still
        // busy with the previous tick (or acking it right now) the tick is lost.
        eligible = active_q & bus.i_ready & ~fail_q;
        if (tick_event) begin
            missed_d = eligible & (tick_q | bus.i_ack);
            tick_d   = tick_q | (eligible & ~bus.i_ack);
        end
        tick_d = tick_d & ~bus.i_ack;

        if (run) begin
            fail_d = fail_q | (bus.i_fail & active_q);
            succ_d = succ_q | (bus.i_success & active_q);
            for (int k = 0; k < N_PLAYERS; k++) begin
                if (bus.i_eat[k] && (score_q[k*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}})) begin
                    score_d[k*SCORE_W +: SCORE_W] = score_q[k*SCORE_W +: SCORE_W] + SCORE_ONE;
                end
            end
        end

        case (state_q)
            S_RUN: begin
                if (!bus.i_mode_ext) begin
                    div_d = (div_q == bus.i_div) ? '0 : div_q + DIV_ONE;
                end
            end
            S_PAUSE: div_d = div_q;
            default: div_d = '0;
        endcase

        // Players joining this very cycle have not failed, so they keep the game alive.
        all_failed = (active_d != '0) && ((active_d & ~fail_d) == '0);
        win        = run && ((bus.i_success & active_q) != '0);

        case (state_q)
            S_IDLE:  if (bus.i_start != '0) state_d = S_RUN;
            S_RUN: begin
                if (win)              state_d = S_WIN;
                else if (all_failed)  state_d = S_OVER;
                else if (bus.i_pause) state_d = S_PAUSE;
            end
            S_PAUSE: if (bus.i_pause) state_d = S_RUN;
            default: state_d = state_q;
        endcase

        if (bus.i_restart) begin
            state_d  = S_IDLE;
            active_d = '0;
            tick_d   = '0;
            missed_d = '0;
            fail_d   = '0;
            succ_d   = '0;
            score_d  = '0;
            div_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            active_q <= '0;
            tick_q   <= '0;
            missed_q <= '0;
            fail_q   <= '0;
            succ_q   <= '0;
            score_q  <= '0;
            div_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            missed_q <= missed_d;
            fail_q   <= fail_d;
            succ_q   <= succ_d;
            score_q  <= score_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
        end
    end

    assign bus.o_tick    = tick_q;
    assign bus.o_missed  = missed_q;
    assign bus.o_state   = state_q;
    assign bus.o_failure = fail_q;
    assign bus.o_success = succ_q;
    assign bus.o_score   = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer with a behavioural model
module tb_game_sequencer;

    localparam int NP  = 2;
    localparam int SW  = 2;
    localparam int DW  = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic clk;
    logic rst_n;

    game_sequencer_if #(.N_PLAYERS(NP), .SCORE_W(SW), .DIV_W(DW)) bus ();

    game_sequencer #(.N_PLAYERS(NP), .SCORE_W(SW), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: game rules expressed with plain integers and masks.
    int         m_state;
    logic [1:0] m_act, m_tick, m_miss, m_fail, m_succ;
    int         m_score [NP];
    int         m_cnt;
    logic       m_phase;
    logic       m_run, m_ev;
    logic [1:0] n_act, n_tick, n_miss, n_fail, n_succ;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_act = 0; m_tick = 0; m_miss = 0; m_fail = 0; m_succ = 0;
            m_score[0] = 0; m_score[1] = 0; m_cnt = 0; m_phase = 1'b0;
        end else if (bus.i_restart) begin
            m_state = 0; m_act = 0; m_tick = 0; m_miss = 0; m_fail = 0; m_succ = 0;
            m_score[0] = 0; m_score[1] = 0; m_cnt = 0; m_phase = bus.i_phase;
        end else begin
            m_run = (m_state == 1);
            m_ev  = 1'b0;
            if (m_run) m_ev = bus.i_mode_ext ? (bus.i_phase != m_phase) : (m_cnt == int'(bus.i_div));
            n_act = m_act;
            if (m_state == 0 || m_state == 1) n_act = m_act | bus.i_start;
            n_fail = m_fail; n_succ = m_succ; n_tick = m_tick; n_miss = 2'b00;
            for (int k = 0; k < NP; k++) begin
                if (m_run && m_act[k]) begin
                    if (bus.i_fail[k])    n_fail[k] = 1'b1;
                    if (bus.i_success[k]) n_succ[k] = 1'b1;
                end
                if (m_run && bus.i_eat[k] && m_score[k] < SMAX) m_score[k] = m_score[k] + 1;
                if (m_ev && m_act[k] && bus.i_ready[k] && !m_fail[k]) begin
                    if (m_tick[k] || bus.i_ack[k]) n_miss[k] = 1'b1;
                    else                           n_tick[k] = 1'b1;
                end
                if (bus.i_ack[k]) n_tick[k] = 1'b0;
            end
            if (m_state == 1) begin
                if (!bus.i_mode_ext) m_cnt = (m_cnt == int'(bus.i_div)) ? 0 : m_cnt + 1;
            end else if (m_state != 2) begin
                m_cnt = 0;
            end
            case (m_state)
                0: if (bus.i_start != 0) m_state = 1;
                1: begin
                    if ((bus.i_success & m_act) != 0)                m_state = 4;
                    else if (n_act != 0 && (n_act & ~n_fail) == 0)  m_state = 3;
                    else if (bus.i_pause)                           m_state = 2;
                end
                2: if (bus.i_pause) m_state = 1;
                default: ;
            endcase
            m_act = n_act; m_tick = n_tick; m_miss = n_miss; m_fail = n_fail; m_succ = n_succ;
            m_phase = bus.i_phase;
        end
    end

    int checks = 0;
    int errors = 0;
    logic auto_ack;
    int rise0, miss0, tick1_cycles;
    logic prev0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state",   32'(bus.o_state),   32'(m_state));
        chk("tick",    32'(bus.o_tick),    32'(m_tick));
        chk("missed",  32'(bus.o_missed),  32'(m_miss));
        chk("failure", 32'(bus.o_failure), 32'(m_fail));
        chk("success", 32'(bus.o_success), 32'(m_succ));
        chk("score",   32'(bus.o_score),   32'(m_score[1] * 4 + m_score[0]));
    endtask

    // One clock: compare at the falling edge, then clear pulses just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        bus.i_restart = 1'b0; bus.i_start = '0; bus.i_pause = 1'b0;
        bus.i_fail = '0; bus.i_success = '0; bus.i_eat = '0;
        if (auto_ack) bus.i_ack = bus.o_tick;
        if (bus.o_tick[0] && !prev0) rise0++;
        prev0 = bus.o_tick[0];
        miss0 += int'(bus.o_missed[0]);
        tick1_cycles += int'(bus.o_tick[1]);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_counts();
        rise0 = 0; miss0 = 0; tick1_cycles = 0;
    endtask

    task automatic restart(input logic ext, input logic [DW-1:0] div);
        bus.i_restart = 1'b1; bus.i_mode_ext = ext; bus.i_div = div;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; auto_ack = 1'b0; prev0 = 1'b0;
        bus.i_restart = 1'b0; bus.i_start = '0; bus.i_pause = 1'b0; bus.i_mode_ext = 1'b0;
        bus.i_phase = 1'b0; bus.i_div = '0; bus.i_ready = '0; bus.i_ack = '0;
        bus.i_fail = '0; bus.i_success = '0; bus.i_eat = '0;
        clear_counts();
        cycles(3);
        chk("reset_state", 32'(bus.o_state), 0);
        chk("reset_tick",  32'(bus.o_tick),  0);
        chk("reset_score", 32'(bus.o_score), 0);
        rst_n = 1'b1;
        cyc();

        // Internal divider of 4 with a prompt ack: one tick per 4 cycles on player 0 only.
        bus.i_mode_ext = 1'b0; bus.i_div = 8'd3; bus.i_ready = 2'b11;
        bus.i_start = 2'b01;
        cyc();
        auto_ack = 1'b1;
        cycles(2);
        clear_counts();
        cycles(40);
        chk("int_state", 32'(bus.o_state), 1);
        chk("int_ticks0", 32'(rise0), 10);
        chk("int_tick1_idle", 32'(tick1_cycles), 0);
        chk("int_no_miss", 32'(miss0), 0);
        auto_ack = 1'b0; bus.i_ack = '0;
        cycles(2);

        // External phase: two changes without ack give one tick and one miss.
        restart(1'b1, 8'd3);
        bus.i_start = 2'b01;
        cyc();
        clear_counts();
        bus.i_phase = ~bus.i_phase; cyc(); cyc();
        bus.i_phase = ~bus.i_phase; cyc();
        cycles(3);
        chk("ext_ticks0", 32'(rise0), 1);
        chk("ext_miss0", 32'(miss0), 1);
        chk("ext_tick_held", 32'(bus.o_tick[0]), 1);
        bus.i_ack = 2'b01; cyc(); bus.i_ack = '0; cyc();

        // Both players fail in turn: game over only after the second.
        restart(1'b0, 8'd200);
        bus.i_start = 2'b11; cyc();
        bus.i_fail = 2'b01; cyc();
        chk("fail1_state", 32'(bus.o_state), 1);
        bus.i_fail = 2'b10; cyc();
        chk("fail2_state", 32'(bus.o_state), 3);
        chk("fail2_flags", 32'(bus.o_failure), 3);
        cycles(2);

        // Success coinciding with the final failure is a win.
        restart(1'b0, 8'd200);
        bus.i_start = 2'b11; cyc();
        bus.i_fail = 2'b01; cyc();
        bus.i_fail = 2'b10; bus.i_success = 2'b10; cyc();
        chk("win_prio", 32'(bus.o_state), 4);
        cycles(2);

        // Score saturation and pause.
        restart(1'b0, 8'd3);
        bus.i_start = 2'b01; cyc();
        for (int i = 0; i < 5; i++) begin
            bus.i_eat = 2'b01; cyc();
        end
        chk("score_sat", 32'(bus.o_score[1:0]), 3);
        bus.i_pause = 1'b1; cyc();
        chk("pause_state", 32'(bus.o_state), 2);
        bus.i_eat = 2'b01; cyc();
        chk("pause_score", 32'(bus.o_score[1:0]), 3);
        cycles(3);
        bus.i_pause = 1'b1; cyc();
        chk("resume_state", 32'(bus.o_state), 1);
        cycles(10);

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.i_restart = ($urandom_range(0, 149) == 0);
            if (bus.i_restart) begin
                bus.i_div = 8'($urandom_range(0, 4));
                bus.i_mode_ext = 1'($urandom_range(0, 1));
            end
            bus.i_start   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.i_pause   = ($urandom_range(0, 29) == 0);
            bus.i_fail    = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
            bus.i_success = {($urandom_range(0, 149) == 0), ($urandom_range(0, 149) == 0)};
            bus.i_eat     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            bus.i_ready   = 2'($urandom_range(0, 3));
            bus.i_ack     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            if ($urandom_range(0, 3) == 0) bus.i_phase = ~bus.i_phase;
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        // Asynchronous reset while a tick is outstanding.
        bus.i_ack = '0;
        restart(1'b0, 8'd2);
        bus.i_ready = 2'b11; bus.i_start = 2'b01; cyc();
        bus.i_eat = 2'b01; cyc();
        cycles(2);
        chk("pre_rst_tick", 32'(bus.o_tick[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_tick",  32'(bus.o_tick),  0);
        chk("rst_score", 32'(bus.o_score), 0);
        chk("rst_flags", 32'({bus.o_failure, bus.o_success, bus.o_missed}), 0);
        cyc();
        rst_n = 1'b1;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of independent snake channels (1..4).
REQ-002 Parameter SCORE_W, default 8: per-player score width.
REQ-003 Parameter DIV_W, default 20: internal tick divider width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_restart  in  1  synchronous game restart, active-high.
REQ-007 i_start  in  N_PLAYERS  per-player join/start request (any direction pressed).
REQ-008 i_pause  in  1  single-cycle pause toggle pulse.
REQ-009 i_mode_ext  in  1  1 = tick on i_phase change; 0 = internal divider.
REQ-010 i_phase  in  1  external tick phase; each change is one tick event.
REQ-011 i_div  in  DIV_W  internal tick period minus 1, in clk cycles.
REQ-012 i_ready  in  N_PLAYERS  channel ready to accept a tick.
REQ-013 i_ack  in  N_PLAYERS  channel has consumed its tick.
REQ-014 i_fail, i_success, i_eat  in  N_PLAYERS each  per-channel event pulses.
REQ-015 o_tick  out  N_PLAYERS  per-channel tick request, held until acked.
REQ-016 o_missed  out  N_PLAYERS  one-cycle pulse, a tick event was dropped.
REQ-017 o_state  out  3  IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4.
REQ-018 o_failure, o_success  out  N_PLAYERS each  sticky per-player flags.
REQ-019 o_score  out  N_PLAYERS*SCORE_W  packed scores, player k at bits [k*SCORE_W +: SCORE_W].

Function
REQ-020 FSM: IDLE->RUN when any i_start bit high; RUN<->PAUSE on each i_pause pulse; RUN->WIN when any i_success[k] of an active player; RUN->OVER when active mask nonzero and every active player has o_failure set (including failures latched this cycle); OVER/WIN hold until i_restart.
REQ-021 WIN has priority over OVER when success and final failure coincide; OVER/WIN have priority over PAUSE.
REQ-022 Active mask: bit k set on i_start[k] in IDLE or RUN; never cleared except by restart/reset.
REQ-023 Tick event, ext mode: in RUN, i_phase != phase_reg; phase_reg then loads i_phase; outside RUN phase_reg loads i_phase every cycle (no burst on resume).
REQ-024 Tick event, internal mode: in RUN, divider counts 0..i_div, event on cycle where count == i_div, count wraps to 0; i_div=0 gives event every RUN cycle; count holds in PAUSE, clears in IDLE/OVER/WIN.
REQ-025 On event, o_tick[k] sets next cycle iff active[k], i_ready[k], !o_failure[k], !o_tick[k], !i_ack[k].
REQ-026 Event while o_tick[k] high or i_ack[k] high (and other REQ-025 terms true): event dropped for k, o_missed[k] pulses next cycle.
REQ-027 i_ack[k] clears o_tick[k] next cycle in every state; ack wins over set.
REQ-028 o_tick retained across PAUSE/OVER/WIN until acked; no new sets outside RUN.
REQ-029 i_fail[k] in RUN sets o_failure[k]; i_success[k] in RUN sets o_success[k]; ignored in other states and for inactive players.
REQ-030 i_eat[k] in RUN increments score k, saturating at 2^SCORE_W-1; ignored elsewhere.
REQ-031 i_mode_ext changes take effect next cycle; divider count unaffected.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, active 0, o_tick 0, o_missed 0, failure/success 0, scores 0, divider 0, phase_reg 0.
REQ-033 i_restart high synchronously forces the same values except phase_reg loads i_phase; restart overrides all other inputs that cycle.
REQ-034 Restart or reset mid-tick clears o_tick without requiring ack.

Verification
REQ-035 Int mode, i_div=3, i_start[0] pulse, i_ready=1, ack 1 cycle after each tick -> o_state=1, o_tick[0] every 4 cycles, o_tick[1]=0.
REQ-036 Ext mode, toggle i_phase twice 2 cycles apart without ack -> one o_tick[0], o_missed[0] pulse once.
REQ-037 Both players active, i_fail[0] then i_fail[1] -> o_state 1 after first, 3 after second; o_failure=2'b11.
REQ-038 Same cycle i_fail on last active player and i_success[1] -> o_state=4.
REQ-039 SCORE_W=2, 5 i_eat[0] pulses in RUN -> score 3; i_pause pulse then i_eat -> state 2, score unchanged, divider frozen.
REQ-040 rst_n low mid-RUN with o_tick high -> all outputs 0 immediately, o_state=0.
